lcd_clkdiv_bank: RTL and testbench

//  Parametrised multi-channel clock-divider bank. Runs on the PLL-derived refclk and

---
 rtl/lcd_clkdiv_bank_if.sv | 24 ++
 rtl/lcd_clkdiv_bank.sv | 155 +++++++++++++++
 tb/tb_lcd_clkdiv_bank.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_clkdiv_bank_if.sv
// Configuration port of the LCD clock-divider bank: one divide/phase update
// per valid/ready transfer, addressed to a single channel.
interface lcd_clkdiv_bank_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/lcd_clkdiv_bank.sv
// lcd_clkdiv_bank: bank of phase-aligned clock dividers for the LCD/i8080
// datapath. Each channel owns a wrap counter whose registered decode gives a
// divided clock and a clock-enable pulse. Divide updates are staged in a shadow
// register and only take effect at a counter wrap, so a running output never
// sees a runt pulse.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | outputs held low, counters frozen, updates apply at once
//  ST_ALIGN | one cycle: every counter loads its start phase
//  ST_RUN   | counters advance and wrap, outputs decoded, lock tracked
module lcd_clkdiv_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 10,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              refclk_i,
    input  logic              reset_n_i,
    input  logic              en_i,
    lcd_clkdiv_bank_if.slave  cfg,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] ce_out_o,
    output logic              locked_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state_q;
    logic [LK_W-1:0]   lock_cnt_q;
    logic [LK_W-1:0]   lock_cnt_d;
    logic              locked_q;
    logic [NUM_CH-1:0] pending_w;
    logic [NUM_CH-1:0] apply_w;
    logic              run_adv;
    logic              accept;
    logic [DIV_W-1:0]  eff_div;
    logic [DIV_W-1:0]  eff_phase;

    assign run_adv       = (state_q == ST_RUN) && en_i;
    assign cfg.cfg_ready = ~|pending_w;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign locked_o      = locked_q;

    // Divide ratios below 2 cannot toggle; a phase outside the period restarts at 0.
    assign eff_div   = (cfg.cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg.cfg_div;
    assign eff_phase = (cfg.cfg_phase < eff_div) ? cfg.cfg_phase : '0;

    // Lock counter: restart on RUN entry and on any applied update, saturate at LOCK_CYCLES.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == ST_ALIGN) begin
            lock_cnt_d = '0;
        end else if (run_adv) begin
            if (|apply_w) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LK_W'(LOCK_CYCLES)) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    // Sequencing FSM with registered lock indicator.
    always_ff @(posedge refclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    locked_q <= 1'b0;
                    if (en_i) state_q <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    locked_q <= 1'b0;
                    state_q  <= en_i ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (!en_i) begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end else begin
                        locked_q <= (lock_cnt_d == LK_W'(LOCK_CYCLES));
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] phase_q;
        logic [DIV_W-1:0] sh_div_q;
        logic [DIV_W-1:0] sh_phase_q;
        logic             pend_q;
        logic             clk_q;
        logic             ce_q;
        logic             hit_w;
        logic             acc_w;

        // >= rather than == keeps the counter bounded even if it ever overshoots.
        assign hit_w        = (cnt_q >= div_q - 1'b1);
        assign acc_w        = accept && (cfg.cfg_ch == CH_W'(i));
        assign apply_w[i]   = pend_q && ((state_q != ST_RUN) || (en_i && hit_w));
        assign pending_w[i] = pend_q;
        assign clk_out_o[i] = clk_q;
        assign ce_out_o[i]  = ce_q;

        // Per-channel shadow staging, wrap counter and registered output decode.
        always_ff @(posedge refclk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_q      <= '0;
                div_q      <= DIV_W'(DEF_DIV);
                phase_q    <= '0;
                sh_div_q   <= DIV_W'(DEF_DIV);
                sh_phase_q <= '0;
                pend_q     <= 1'b0;
                clk_q      <= 1'b0;
                ce_q       <= 1'b0;
            end else begin
                if (acc_w) begin
                    sh_div_q   <= eff_div;
                    sh_phase_q <= eff_phase;
                    pend_q     <= 1'b1;
                end else if (apply_w[i]) begin
                    div_q   <= sh_div_q;
                    phase_q <= sh_phase_q;
                    pend_q  <= 1'b0;
                end
                case (state_q)
                    ST_ALIGN: cnt_q <= apply_w[i] ? sh_phase_q : phase_q;
                    ST_RUN: begin
                        if (en_i) cnt_q <= hit_w ? '0 : cnt_q + 1'b1;
                    end
                    default: cnt_q <= cnt_q;
                endcase
                clk_q <= run_adv && (cnt_q < (div_q >> 1));
                ce_q  <= run_adv && (cnt_q == '0);
            end
        end
    end
endmodule

// File: tb/tb_lcd_clkdiv_bank.sv
// Testbench for lcd_clkdiv_bank. Built with three channels so the 2-bit channel
// field has one unused code (3) to exercise the out-of-range discard path.
module tb_lcd_clkdiv_bank;
    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam int CAP = 64;

    logic           refclk = 1'b0;
    logic           reset_n;
    logic           en;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] ce_out;
    logic           locked;

    lcd_clkdiv_bank_if #(.NUM_CH(NCH), .DIV_W(DW)) ifc ();

    lcd_clkdiv_bank #(
        .NUM_CH(NCH), .DIV_W(DW), .DEF_DIV(10), .LOCK_CYCLES(16)
    ) dut (
        .refclk_i  (refclk),
        .reset_n_i (reset_n),
        .en_i      (en),
        .cfg       (ifc),
        .clk_out_o (clk_out),
        .ce_out_o  (ce_out),
        .locked_o  (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string       tag;
        logic [31:0] want;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [NCH-1:0] ce_tr  [CAP];
    logic [NCH-1:0] clk_tr [CAP];
    logic           lk_tr  [CAP];
    logic           rdy_tr [CAP];
    int             cap_n = 0;

    function automatic void push(string tag, logic [31:0] want);
        exp_t e;
        e.tag  = tag;
        e.want = want;
        sb.push_back(e);
    endfunction

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_underflow observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.want) else begin
                n_errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.want);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Records n cycles of outputs; any pending config request is dropped after the first edge.
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge refclk);
            ce_tr[k]  = ce_out;
            clk_tr[k] = clk_out;
            lk_tr[k]  = locked;
            rdy_tr[k] = ifc.cfg_ready;
            ifc.cfg_valid = 1'b0;
        end
        cap_n = n;
    endtask

    task automatic cfg_write(input int ch, input int dv, input int ph);
        int n = 0;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_ch    = ch[1:0];
        ifc.cfg_div   = dv[7:0];
        ifc.cfg_phase = ph[7:0];
        while (ifc.cfg_ready !== 1'b1 && n < 100) begin
            @(negedge refclk);
            n++;
        end
        @(negedge refclk);
        ifc.cfg_valid = 1'b0;
        push("cfg_accept_in_time", 1);
        pop_check((n < 100) ? 32'd1 : 32'd0);
    endtask

    function automatic int find_ce(input int ch, input int from);
        if (from < 0) return -1;
        for (int k = from; k < cap_n; k++) if (ce_tr[k][ch] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int count_clk(input int ch, input int a, input int b);
        int c = 0;
        if (a < 0 || b < 0) return -1;
        for (int k = a; k < b; k++) if (clk_tr[k][ch] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_lk(input int from);
        for (int k = from; k < cap_n; k++) if (lk_tr[k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int first_rdy(input int from);
        for (int k = from; k < cap_n; k++) if (rdy_tr[k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int skew_count();
        int c = 0;
        for (int k = 0; k < cap_n; k++) begin
            if ((ce_tr[k] !== '0 && ce_tr[k] !== '1) || (clk_tr[k] !== '0 && clk_tr[k] !== '1)) c++;
        end
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        reset_n = 1'b0;
        en = 1'b0;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_ch    = '0;
        ifc.cfg_div   = '0;
        ifc.cfg_phase = '0;
        tick(2);

        // Reset state
        push("rst_clk_out", 0); push("rst_ce_out", 0); push("rst_locked", 0); push("rst_cfg_ready", 1);
        pop_check(32'(clk_out)); pop_check(32'(ce_out)); pop_check(32'(locked)); pop_check(32'(ifc.cfg_ready));

        // Defaults: divide by 10, all channels in phase, lock after 16 RUN cycles
        reset_n = 1'b1;
        tick(1);
        en = 1'b1;
        push("t1_ce0_first", 2); push("t1_ce0_next", 12); push("t1_clk0_high", 5);
        push("t1_clk0_at_ce", 1); push("t1_channel_skew", 0); push("t1_lock_first", 17);
        capture(40);
        a = find_ce(0, 0); b = find_ce(0, a + 1);
        pop_check(a); pop_check(b); pop_check(count_clk(0, a, b));
        pop_check(32'(clk_tr[2][0])); pop_check(skew_count()); pop_check(first_lk(0));

        // Odd divide on ch0 written in IDLE
        en = 1'b0;
        tick(2);
        cfg_write(0, 3, 0);
        tick(1);
        push("t2_ready_after_apply", 1);
        pop_check(32'(ifc.cfg_ready));
        en = 1'b1;
        push("t2_ce0_first", 2); push("t2_ce0_next", 5); push("t2_clk0_high", 1); push("t2_ce1_next", 12);
        capture(30);
        a = find_ce(0, 0); b = find_ce(0, a + 1);
        pop_check(a); pop_check(b); pop_check(count_clk(0, a, b)); pop_check(find_ce(1, 3));

        // Start phase: ch1 preloaded with 5
        en = 1'b0;
        tick(2);
        cfg_write(0, 10, 0);
        cfg_write(1, 10, 5);
        tick(1);
        en = 1'b1;
        push("t3_ce0_first", 2); push("t3_ce1_first", 7); push("t3_ce1_next", 17);
        push("t3_clk1_high", 5); push("t3_clk1_at_start", 0);
        capture(40);
        pop_check(find_ce(0, 0)); a = find_ce(1, 0); b = find_ce(1, a + 1);
        pop_check(a); pop_check(b); pop_check(count_clk(1, a, b)); pop_check(32'(clk_tr[2][1]));

        // Live update of ch2 to div 4 while running (ch2 counter is at 8 here)
        ifc.cfg_valid = 1'b1;
        ifc.cfg_ch    = 2'd2;
        ifc.cfg_div   = 8'd4;
        ifc.cfg_phase = 8'd0;
        push("t4_ready_pending", 0); push("t4_ready_back", 1); push("t4_clk2_tail", 0);
        push("t4_ce2_first", 2); push("t4_ce2_next", 6); push("t4_clk2_high", 2);
        push("t4_lock_before", 1); push("t4_lock_drop", 0); push("t4_lock_back", 17); push("t4_ce0_next", 12);
        capture(40);
        pop_check(32'(rdy_tr[0])); pop_check(first_rdy(0)); pop_check(count_clk(2, 0, 2));
        a = find_ce(2, 0); b = find_ce(2, a + 1);
        pop_check(a); pop_check(b); pop_check(count_clk(2, a, b));
        pop_check(32'(lk_tr[0])); pop_check(32'(lk_tr[1])); pop_check(first_lk(1)); pop_check(find_ce(0, 3));

        // Clamping and out-of-range channel
        en = 1'b0;
        tick(2);
        cfg_write(0, 0, 0);
        tick(1);
        cfg_write(1, 10, 12);
        push("t5_goodch_ready", 0);
        pop_check(32'(ifc.cfg_ready));
        tick(1);
        cfg_write(3, 5, 1);
        push("t5_badch_ready", 1);
        pop_check(32'(ifc.cfg_ready));
        en = 1'b1;
        push("t5_ce0_first", 2); push("t5_ce0_next", 4); push("t5_clk0_high", 1);
        push("t5_ce1_first", 2); push("t5_ce1_next", 12); push("t5_ce2_first", 2); push("t5_ce2_next", 6);
        capture(30);
        a = find_ce(0, 0); b = find_ce(0, a + 1);
        pop_check(a); pop_check(b); pop_check(count_clk(0, a, b));
        a = find_ce(1, 0); pop_check(a); pop_check(find_ce(1, a + 1));
        a = find_ce(2, 0); pop_check(a); pop_check(find_ce(2, a + 1));

        // en dropped while ch0 is about to pulse, then reset while an update is pending
        push("t6_locked_before", 1);
        pop_check(32'(locked));
        en = 1'b0;
        tick(1);
        push("t6_clk_off", 0); push("t6_ce_off", 0); push("t6_lock_off", 0);
        pop_check(32'(clk_out)); pop_check(32'(ce_out)); pop_check(32'(locked));
        en = 1'b1;
        tick(6);
        ifc.cfg_valid = 1'b1;
        ifc.cfg_ch    = 2'd1;
        ifc.cfg_div   = 8'd6;
        ifc.cfg_phase = 8'd0;
        tick(1);
        ifc.cfg_valid = 1'b0;
        push("t6_ready_pending", 0);
        pop_check(32'(ifc.cfg_ready));
        reset_n = 1'b0;
        en = 1'b0;
        #1;
        push("t6_rst_clk", 0); push("t6_rst_ce", 0); push("t6_rst_lock", 0); push("t6_rst_ready", 1);
        pop_check(32'(clk_out)); pop_check(32'(ce_out)); pop_check(32'(locked)); pop_check(32'(ifc.cfg_ready));
        tick(2);
        reset_n = 1'b1;
        tick(1);
        en = 1'b1;
        push("t6_ce0_first", 2); push("t6_ce0_next", 12); push("t6_ce1_next", 12); push("t6_lock_first", 17);
        capture(30);
        a = find_ce(0, 0);
        pop_check(a); pop_check(find_ce(0, a + 1)); pop_check(find_ce(1, 3)); pop_check(first_lk(0));

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
